// File: rtl/vec_csr_pkg.sv
// Shared types for the vector CSR unit: CSR addresses, vtype field encodings, op codes and FSM states.
package vec_csr_pkg;

    typedef enum logic [11:0] {
        CSR_VSTART = 12'h008,
        CSR_VXSAT  = 12'h009,
        CSR_VXRM   = 12'h00A,
        CSR_VCSR   = 12'h00F,
        CSR_VL     = 12'hC20,
        CSR_VTYPE  = 12'hC21,
        CSR_VLENB  = 12'hC22
    } csr_reg_e;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

    typedef enum logic [2:0] {
        EW_8  = 3'b000,
        EW_16 = 3'b001,
        EW_32 = 3'b010,
        EW_64 = 3'b011
    } vew_e;

    typedef struct packed {
        logic   vill;
        logic   vma;
        logic   vta;
        vew_e   vsew;
        vlmul_e vlmul;
    } csr_vtype_s;

    typedef enum logic [2:0] {
        OP_VSETVLI  = 3'd0,
        OP_VSETIVLI = 3'd1,
        OP_VSETVL   = 3'd2,
        OP_CSR      = 3'd3
    } vec_cfg_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } csr_state_e;

    localparam csr_vtype_s VTYPE_ILL = '{vill: 1'b1, vma: 1'b0, vta: 1'b0, vsew: EW_8, vlmul: LMUL_1};

endpackage

// File: rtl/vec_vtype_decode.sv
// Combinational vtype decode: legality (vill), SEW in bits and VLMAX for a raw XLEN-wide vtype.
module vec_vtype_decode
    import vec_csr_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned VLEN = 512,
    parameter int unsigned ELEN = 64
) (
    input  logic [XLEN-1:0]        vtype_raw,
    output logic                   vill,
    output logic [6:0]             sew,
    output logic [$clog2(VLEN):0]  vlmax
);
    localparam int unsigned VLMAX_W = $clog2(VLEN) + 1;

    logic [2:0]  vsew_f;
    logic [2:0]  vlmul_f;
    logic        rsvd_nz;
    logic        frac;
    int unsigned sew_bits;
    int unsigned base_elems;
    int unsigned frac_sh;
    int unsigned vlmax_full;
    logic        unused_policy;

    assign unused_policy = ^vtype_raw[7:6];

    always_comb begin
        vsew_f     = vtype_raw[5:3];
        vlmul_f    = vtype_raw[2:0];
        rsvd_nz    = |vtype_raw[XLEN-1:8];
        frac       = vlmul_f[2];
        sew_bits   = 32'd8 << vsew_f[1:0];
        base_elems = VLEN >> (32'd3 + 32'(vsew_f[1:0]));
        frac_sh    = 32'd8 - 32'(vlmul_f);
        vlmax_full = frac ? (base_elems >> frac_sh) : (base_elems << vlmul_f[1:0]);
        // Fractional LMUL is only legal while SEW still fits in LMUL*ELEN
        vill = rsvd_nz || (vlmul_f == LMUL_RSVD) || vsew_f[2] || (sew_bits > ELEN)
            || (frac && (sew_bits > (ELEN >> frac_sh)));
        sew   = vill ? 7'd8 : 7'(sew_bits);
        vlmax = vill ? '0 : VLMAX_W'(vlmax_full);
    end

endmodule

// File: rtl/vec_csr_unit.sv
// Vector CSR unit: vset{i}vl{i} execution and Zicsr access to vstart/vl/vtype/vlenb.
// Define VEC_FIXED_POINT_CSR_EN to add the vxsat/vxrm/vcsr fixed-point CSRs.
module vec_csr_unit
    import vec_csr_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned VLEN = 512,
    parameter int unsigned ELEN = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [XLEN-1:0]        req_inst,
    input  logic [XLEN-1:0]        req_rs1_data,
    input  logic [XLEN-1:0]        req_rs2_data,
    output logic                   resp_valid,
    output logic [XLEN-1:0]        resp_data,
    output logic                   resp_illegal,
    input  logic                   vstart_clr,
    output logic [2:0]             vlmul,
    output logic [6:0]             sew,
    output logic [$clog2(VLEN):0]  vlmax,
    output logic [XLEN-1:0]        vl,
    output logic [XLEN-1:0]        vstart,
    output logic                   vta,
    output logic                   vma,
    output logic                   vill,
    output logic [1:0]             vxrm,
    output logic                   vxsat,
    input  logic                   vxsat_set
);
    localparam int unsigned VLMAX_W = $clog2(VLEN) + 1;
    localparam logic [XLEN-1:0] VSTART_MASK = XLEN'({VLMAX_W{1'b1}});

    csr_state_e  state_q, state_d;
    vec_cfg_op_e op_q;
    logic [XLEN-1:0] inst_q, rs1_q, rs2_q;
    csr_vtype_s  vtype_q;
    logic [XLEN-1:0] vl_q, vstart_q;

    csr_vtype_s  cm_vtype_q, c_vtype;
    logic [XLEN-1:0] cm_vl_q, cm_wdata_q, c_vl, c_resp;
    logic        cm_vset_q, cm_vstart_we_q, c_vset, c_vstart_we, c_illegal;

    logic [4:0]  rs1_f, rd_f;
    logic [2:0]  funct3;
    logic [XLEN-1:0] vtype_src, vtype_rd, avl, vlmax_x, set_vl;
    logic [XLEN-1:0] csr_src, csr_old, csr_new;
    logic        keep_vl, set_vill, csr_wr, csr_known, csr_ro, csr_bad;
    logic        calc_vill, out_vill;
    logic [6:0]  calc_sew;
    logic [VLMAX_W-1:0] calc_vlmax;
    logic        commit;
    logic        unused_bits;

`ifdef VEC_FIXED_POINT_CSR_EN
    logic        vxsat_q;
    logic [1:0]  vxrm_q;
    logic [2:0]  cm_fp_q, c_fp;
    logic        cm_vxsat_we_q, cm_vxrm_we_q, c_vxsat_we, c_vxrm_we;
`endif

    assign rs1_f    = inst_q[19:15];
    assign rd_f     = inst_q[11:7];
    assign funct3   = inst_q[14:12];
    assign commit   = (state_q == COMMIT);
    assign vtype_rd = {vtype_q.vill, {(XLEN-9){1'b0}}, vtype_q.vma, vtype_q.vta, vtype_q.vsew, vtype_q.vlmul};

    assign vlmul  = vtype_q.vlmul;
    assign vta    = vtype_q.vta;
    assign vma    = vtype_q.vma;
    assign vill   = vtype_q.vill;
    assign vl     = vl_q;
    assign vstart = vstart_q;
    assign unused_bits = ^{inst_q[6:0], calc_sew, out_vill};

    vec_vtype_decode #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) u_calc_decode (
        .vtype_raw (vtype_src),
        .vill      (calc_vill),
        .sew       (calc_sew),
        .vlmax     (calc_vlmax)
    );

    // The readback form carries vill in the top bit, which the decoder treats as reserved
    vec_vtype_decode #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) u_out_decode (
        .vtype_raw (vtype_rd),
        .vill      (out_vill),
        .sew       (sew),
        .vlmax     (vlmax)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && req_ready) state_d = CALC;
            CALC:    state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CALC-stage evaluation of the registered request
    always_comb begin
        case (op_q)
            OP_VSETVLI:  vtype_src = XLEN'(inst_q[30:20]);
            OP_VSETIVLI: vtype_src = XLEN'(inst_q[29:20]);
            default:     vtype_src = rs2_q;
        endcase

        keep_vl = 1'b0;
        if (op_q == OP_VSETIVLI)  avl = XLEN'(rs1_f);
        else if (rs1_f != 5'd0)   avl = rs1_q;
        else if (rd_f != 5'd0)    avl = '1;
        else begin
            avl     = vl_q;
            keep_vl = 1'b1;
        end
        vlmax_x  = XLEN'(calc_vlmax);
        set_vill = calc_vill || (keep_vl && (vl_q > vlmax_x));
        set_vl   = (avl < vlmax_x) ? avl : vlmax_x;

        csr_src   = funct3[2] ? XLEN'(rs1_f) : rs1_q;
        csr_wr    = (funct3[1:0] == 2'b01) || (rs1_f != 5'd0);
        csr_known = 1'b1;
        csr_ro    = 1'b0;
        csr_old   = '0;
        case (inst_q[31:20])
            CSR_VSTART: csr_old = vstart_q;
            CSR_VL:     begin csr_old = vl_q;            csr_ro = 1'b1; end
            CSR_VTYPE:  begin csr_old = vtype_rd;        csr_ro = 1'b1; end
            CSR_VLENB:  begin csr_old = XLEN'(VLEN / 8); csr_ro = 1'b1; end
`ifdef VEC_FIXED_POINT_CSR_EN
            CSR_VXSAT:  csr_old = XLEN'(vxsat_q);
            CSR_VXRM:   csr_old = XLEN'(vxrm_q);
            CSR_VCSR:   csr_old = XLEN'({vxrm_q, vxsat_q});
`endif
            default:    csr_known = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   csr_new = csr_src;
            2'b10:   csr_new = csr_old | csr_src;
            default: csr_new = csr_old & ~csr_src;
        endcase
        csr_bad = !csr_known || (funct3[1:0] == 2'b00) || (csr_ro && csr_wr);

        c_vset      = 1'b0;
        c_vstart_we = 1'b0;
        c_illegal   = 1'b0;
        c_resp      = '0;
        c_vtype     = vtype_q;
        c_vl        = vl_q;
`ifdef VEC_FIXED_POINT_CSR_EN
        c_vxsat_we  = 1'b0;
        c_vxrm_we   = 1'b0;
        c_fp        = csr_new[2:0];
`endif
        if (op_q == OP_CSR) begin
            if (csr_bad) begin
                c_illegal = 1'b1;
            end else begin
                c_resp = csr_old;
                if (csr_wr) begin
                    case (inst_q[31:20])
                        CSR_VSTART: c_vstart_we = 1'b1;
`ifdef VEC_FIXED_POINT_CSR_EN
                        CSR_VXSAT:  begin c_vxsat_we = 1'b1; c_fp = {2'b00, csr_new[0]}; end
                        CSR_VXRM:   begin c_vxrm_we  = 1'b1; c_fp = {csr_new[1:0], 1'b0}; end
                        CSR_VCSR:   begin c_vxsat_we = 1'b1; c_vxrm_we = 1'b1; end
`endif
                        default:    c_vstart_we = 1'b0;
                    endcase
                end
            end
        end else if (op_q == OP_VSETVLI || op_q == OP_VSETIVLI || op_q == OP_VSETVL) begin
            c_vset = 1'b1;
            if (set_vill) begin
                c_vtype = VTYPE_ILL;
                c_vl    = '0;
            end else begin
                c_vtype = csr_vtype_s'({1'b0, vtype_src[7:0]});
                c_vl    = set_vl;
                c_resp  = set_vl;
            end
        end else begin
            c_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request capture, CALC results and the response pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready      <= 1'b1;
            op_q           <= OP_VSETVLI;
            inst_q         <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            resp_valid     <= 1'b0;
            resp_data      <= '0;
            resp_illegal   <= 1'b0;
            cm_vset_q      <= 1'b0;
            cm_vstart_we_q <= 1'b0;
            cm_vtype_q     <= VTYPE_ILL;
            cm_vl_q        <= '0;
            cm_wdata_q     <= '0;
        end else begin
            req_ready  <= (state_d == IDLE);
            resp_valid <= (state_q == CALC);
            if (state_q == IDLE && req_valid && req_ready) begin
                op_q   <= vec_cfg_op_e'(req_op);
                inst_q <= req_inst;
                rs1_q  <= req_rs1_data;
                rs2_q  <= req_rs2_data;
            end
            if (state_q == CALC) begin
                resp_data      <= c_resp;
                resp_illegal   <= c_illegal;
                cm_vset_q      <= c_vset;
                cm_vstart_we_q <= c_vstart_we;
                cm_vtype_q     <= c_vtype;
                cm_vl_q        <= c_vl;
                cm_wdata_q     <= csr_new;
            end
        end
    end

    // Architectural state; a committed vstart write beats a same-cycle vstart_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vtype_q  <= VTYPE_ILL;
            vl_q     <= '0;
            vstart_q <= '0;
        end else begin
            if (commit && cm_vset_q) begin
                vtype_q <= cm_vtype_q;
                vl_q    <= cm_vl_q;
            end
            if (commit && cm_vstart_we_q)  vstart_q <= cm_wdata_q & VSTART_MASK;
            else if (commit && cm_vset_q)  vstart_q <= '0;
            else if (vstart_clr)           vstart_q <= '0;
        end
    end

`ifdef VEC_FIXED_POINT_CSR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_vxsat_we_q <= 1'b0;
            cm_vxrm_we_q  <= 1'b0;
            cm_fp_q       <= '0;
            vxsat_q       <= 1'b0;
            vxrm_q        <= 2'b00;
        end else begin
            if (state_q == CALC) begin
                cm_vxsat_we_q <= c_vxsat_we;
                cm_vxrm_we_q  <= c_vxrm_we;
                cm_fp_q       <= c_fp;
            end
            if (commit && cm_vxsat_we_q) vxsat_q <= cm_fp_q[0];
            else if (vxsat_set)          vxsat_q <= 1'b1;
            if (commit && cm_vxrm_we_q)  vxrm_q  <= cm_fp_q[2:1];
        end
    end

    assign vxsat = vxsat_q;
    assign vxrm  = vxrm_q;
`else
    logic unused_vxsat_set;
    assign unused_vxsat_set = vxsat_set;
    assign vxsat = 1'b0;
    assign vxrm  = 2'b00;
`endif

endmodule

// File: doc/vec_csr_unit.md
Name: vec_csr_unit

Overview:
- Parametrised next-generation vector CSR block. Owns vtype, vl, vstart and the read-only vlenb.
- Executes vsetvli, vsetivli and vsetvl with full AVL→vl computation, including fractional LMUL and vill detection.
- Executes Zicsr accesses to the vector CSRs through a valid/ready request and pulsed-response handshake.
- Sits between the vector decode stage and the vector datapath; the datapath consumes the decoded configuration outputs.

Parameters:
- XLEN, 32, scalar register and CSR width.
- VLEN, 512, vector register length in bits; power of two, 64..4096.
- ELEN, 64, maximum element width; 32 or 64.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  vec_cfg_op_e: VSETVLI, VSETIVLI, VSETVL, CSR.
- req_inst  in  XLEN  full instruction word.
- req_rs1_data  in  XLEN  AVL, or CSR source operand.
- req_rs2_data  in  XLEN  vtype source for VSETVL.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  XLEN  new vl (vset ops), or old CSR value (CSR op).
- resp_illegal  out  1  qualified by resp_valid.
- vstart_clr  in  1  vector instruction retired; clears vstart.
- vlmul  out  3  raw vtype.vlmul.
- sew  out  7  8/16/32/64.
- vlmax  out  $clog2(VLEN)+1  current VLMAX.
- vl  out  XLEN  vector length.
- vstart  out  XLEN  start element.
- vta, vma, vill  out  1 each  vtype fields.
- vxrm  out  2  rounding mode (see Optional Feature).
- vxsat  out  1  saturation flag (see Optional Feature).
- vxsat_set  in  1  datapath saturation event (see Optional Feature).

Behaviour:
- Reset: vill=1; vta, vma, vsew, vlmul = 0; vl=0; vstart=0; FSM=IDLE; resp_valid=0; resp_data=0; resp_illegal=0.
- FSM states and transitions:
  - IDLE → CALC on req_valid & req_ready; the request is registered.
  - CALC: decodes vtype, checks legality, computes VLMAX and AVL; → COMMIT.
  - COMMIT: updates registers, pulses resp_valid; → IDLE.
  - Latency is exactly 2 cycles from accept to resp_valid. Throughput is one request per 3 cycles.
- vtype source:
  - VSETVLI: inst[30:20].
  - VSETIVLI: inst[29:20].
  - VSETVL: rs2_data.
- VLMAX calculation:
  - VLMAX = (VLEN >> (3+vsew)) << vlmul for vlmul 000..011.
  - VLMAX = (VLEN >> (3+vsew)) >> (8-vlmul) for vlmul 101..111.
- vill is set when any of the following hold:
  - vlmul = 100;
  - SEW > ELEN;
  - vsew ≥ 100;
  - nonzero reserved bits;
  - fractional LMUL with SEW > LMUL*ELEN.
- When vill is set: vtype = {1, 0...}, vl=0, resp_data=0, resp_illegal=0. vill is architectural state, not a trap.
- AVL rules:
  - VSETIVLI: AVL = zero-extended inst[19:15].
  - rs1≠x0: AVL = rs1_data.
  - rs1=x0, rd≠x0: AVL = all-ones, giving vl=VLMAX.
  - rs1=x0, rd=x0: vl is kept. If the kept vl > new VLMAX, vill is set instead.
- vl = min(AVL, VLMAX), using an unsigned XLEN-bit compare.
- Every successful vset op clears vstart.
- CSR op:
  - funct3 001/010/011/101/110/111 selects rw/rs/rc/rwi/rsi/rci. The immediate forms use zero-extended inst[19:15].
  - vstart (0x008) is read/write. Bits above $clog2(VLEN) are written as 0.
  - vl (0xC20), vtype (0xC21) and vlenb (0xC22, = VLEN/8) are read-only. A write attempt (rw, or rs/rc with rs1≠0) is illegal.
  - resp_data is the pre-write value.
  - Illegal requests: unknown address, illegal write, or bad funct3. Response is resp_illegal=1, resp_data=0, no state change.
- vtype readback = {vill, XLEN-9 zeros, vma, vta, vsew, vlmul}.
- Simultaneous events: a vstart_clr in the same cycle as a COMMIT write to vstart loses; the CSR write wins. vstart_clr is otherwise accepted in any state.
- Reset mid-operation: the FSM returns to IDLE, no response is issued, and registers take reset values.
- sew and vlmax are combinational from the registered vtype. When vill=1: sew=8, vlmax=0.

Optional Feature:
- Macro: VEC_FIXED_POINT_CSR_EN.
- Defined:
  - Adds vxsat (0x009, 1 bit), vxrm (0x00A, 2 bits) and vcsr (0x00F = {vxrm, vxsat}), all readable/writable via the CSR op.
  - vxsat_set sets vxsat, with priority below a same-cycle CSR write.
  - vxsat and vxrm reset to 0.
- Undefined: these addresses are illegal; vxrm, vxsat tied 0; vxsat_set ignored.

Decomposition:
- Package vec_csr_pkg holds:
  - csr_reg_e addresses, including 0xC22 and the fixed-point addresses;
  - vlmul_e with fractional encodings;
  - vew_e;
  - csr_vtype_s;
  - vec_cfg_op_e;
  - csr_state_e {IDLE, CALC, COMMIT}.
- Sub-module vec_vtype_decode (combinational): vtype + ELEN/VLEN → vill, sew, vlmax. This module is instantiated in the CALC path and for the vlmax/sew outputs.

Test Plan (VLEN=512, ELEN=64):
- VSETVLI rs1≠x0, rs1_data=100, e32 m2 → VLMAX=32; vl=32; resp_data=32 exactly 2 cycles after accept; vstart=0.
- VSETVLI rs1=x0 rd≠x0, e8 mf2 → vl=32. Then VSETVLI rs1=rd=x0, e64 m1 (VLMAX=8) → vill=1, vl=0.
- VSETVL rs2_data selecting e64 mf8 → vill=1; csrrs vtype rs1=x0 returns 0x8000_0000; sew=8; vlmax=0.
- csrrw vstart 0x25 with vstart_clr in the COMMIT cycle → vstart=0x25, resp_data=old value. csrrs vl rs1=x3 → resp_illegal=1, vl unchanged.
- rst pulsed during CALC → no resp_valid; vill=1, vl=0, req_ready=1 next cycle.
- With VEC_FIXED_POINT_CSR_EN: csrrwi vxrm 2 then vxsat_set → vcsr reads 0x5. Without the macro: same access → resp_illegal=1.
